// File: rtl/kronos_types.sv
// Kronos shared types.
// Memory arbiter ownership and state encoding.
package kronos_types;

  localparam int unsigned RUN_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/kronos_mem_arb.sv
// Kronos memory arbiter: fetch and load/store ports
// sharing one single-port memory.
import kronos_types::*;

module kronos_mem_arb #(
  parameter int unsigned MAX_DATA_RUN = 4
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] instr_addr,
  input  logic        instr_req,
  output logic        instr_gnt,
  output logic [31:0] instr_data,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_mask,
  input  logic        data_wr_en,
  input  logic        data_req,
  output logic        data_gnt,
  output logic [31:0] data_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mask,
  output logic        mem_wr_en,
  output logic        mem_req,
  input  logic        mem_gnt,
  input  logic [31:0] mem_rdata
);

  localparam logic [RUN_W-1:0] RUN_MAX =
    RUN_W'(MAX_DATA_RUN);

  arb_state_t       state;
  arb_state_t       state_nxt;
  arb_state_t       owner;
  logic [RUN_W-1:0] run_cnt;
  logic             run_ok;
  logic             sel_i;
  logic             sel_d;

  assign run_ok = run_cnt < RUN_MAX;

  // Busy states hold the latched owner; idle picks combinationally
  always_comb begin
    owner = IDLE;
    unique case (state)
      BUSY_I: owner = BUSY_I;
      BUSY_D: owner = BUSY_D;
      default: begin
        if (data_req && run_ok)
          owner = BUSY_D;
        else if (instr_req)
          owner = BUSY_I;
        else if (data_req)
          owner = BUSY_D;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      if (owner != IDLE && !mem_gnt)
        state_nxt = owner;
    end else if (mem_gnt) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  assign sel_i = (owner == BUSY_I);
  assign sel_d = (owner == BUSY_D);

  assign mem_req   = sel_i | sel_d;
  assign instr_gnt = mem_gnt & sel_i;
  assign data_gnt  = mem_gnt & sel_d;

  assign instr_data = mem_rdata;
  assign data_rdata = mem_rdata;

  // Fetches never write, whatever the data port is holding
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_mask  = '0;
    mem_wr_en = 1'b0;
    unique case (1'b1)
      sel_d: begin
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
        mem_mask  = data_mask;
        mem_wr_en = data_wr_en;
      end
      sel_i: begin
        mem_addr  = instr_addr;
      end
      default: ;
    endcase
  end

  // Bounds how long a waiting fetch can be starved by data traffic
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz)
      run_cnt <= '0;
    else if (!instr_req || instr_gnt)
      run_cnt <= '0;
    else if (data_gnt && run_ok)
      run_cnt <= run_cnt + 1'b1;
  end

endmodule
